// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity encodings and frame-size helper for the UART TX engine
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   function automatic int unsigned frame_bits(input int unsigned data_w,
                                              input logic [1:0] par,
                                              input logic stop2);
      int unsigned n;
      n = 32'd1 + data_w + (stop2 ? 32'd2 : 32'd1);
      if (par == PAR_EVEN || par == PAR_ODD) n = n + 32'd1;
      return n;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time down-counter; bit_tick marks the last clock of each bit
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick
);

   logic [DIV_W-1:0] cnt;

   assign bit_tick = (cnt == '0);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst)                      cnt <= '0;
      else if (restart || bit_tick) cnt <= div;
      else                          cnt <= cnt - DIV_W'(1);
   end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - UART TX frame FSM with runtime parity/stop/baud selection
// Optional line-break support when UART_TX_BREAK_EN is defined.
module uart_tx_frame_engine
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 16
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [1:0]        parity_mode,
   input  logic              stop2,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   output logic              tx_busy,
   output logic              tx_done
`ifdef UART_TX_BREAK_EN
   ,
   input  logic              break_req
`endif
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   tx_state_t         state, state_nxt;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic              stop_cnt;
   logic              par_bit;
   logic              has_par;
   logic              stop2_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_sel;
   logic              bit_tick;
   logic              restart;
   logic              accept;
   logic              last_stop;
   logic              brk_req;

`ifdef UART_TX_BREAK_EN
   assign brk_req = break_req;
`else
   assign brk_req = 1'b0;
`endif

   assign tx_busy = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
   // Outside a frame the counter follows the live divider so break release and restarts use it.
   assign div_sel = (accept || state == IDLE || state == BRK) ? clk_div : div_q;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk1     (clk1),
      .rst      (rst),
      .restart  (restart),
      .div      (div_sel),
      .bit_tick (bit_tick)
   );

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      tx_done   = 1'b0;
      txd       = 1'b1;
      restart   = 1'b0;
      last_stop = !stop2_q || stop_cnt;
      case (state)
         IDLE: begin
            txd      = !brk_req;
            tx_ready = !brk_req;
            if (brk_req) begin
               state_nxt = BRK;
               restart   = 1'b1;
            end
         end
         START:  if (bit_tick) state_nxt = DATA;
         DATA: begin
            txd = shreg[0];
            if (bit_tick && bit_idx == IDX_W'(DATA_W - 1))
               state_nxt = has_par ? PARITY : STOP;
         end
         PARITY: begin
            txd = par_bit;
            if (bit_tick) state_nxt = STOP;
         end
         STOP: begin
            if (bit_tick && last_stop) begin
               tx_done   = 1'b1;
               tx_ready  = !brk_req;
               state_nxt = brk_req ? BRK : IDLE;
               restart   = brk_req;
            end
         end
         BRK: begin
            // Counter is held at reload while break is asserted, so release gives one full bit of idle.
            txd = !brk_req;
            if (brk_req)       restart   = 1'b1;
            else if (bit_tick) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state == START) txd = 1'b0;
      accept = tx_valid && tx_ready;
      if (accept) begin
         state_nxt = START;
         restart   = 1'b1;
      end
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         par_bit  <= 1'b0;
         has_par  <= 1'b0;
         stop2_q  <= 1'b0;
         div_q    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            shreg    <= tx_data;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            div_q    <= clk_div;
            stop2_q  <= stop2;
            has_par  <= (parity_mode != PAR_NONE) && (parity_mode != 2'b11);
            par_bit  <= (parity_mode == PAR_ODD) ? ~^tx_data : ^tx_data;
         end else if (bit_tick) begin
            if (state == DATA) begin
               shreg   <= {1'b0, shreg[DATA_W-1:1]};
               bit_idx <= bit_idx + IDX_W'(1);
            end
            if (state == STOP) stop_cnt <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb/tb_uart_tx_frame_engine.sv - randomized self-checking bench against a bit-list frame model
module tb_uart_tx_frame_engine;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 16;

   logic              clk1 = 1'b0;
   logic              rst;
   logic [DIV_W-1:0]  clk_div;
   logic [1:0]        parity_mode;
   logic              stop2;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready, txd, tx_busy, tx_done;
`ifdef UART_TX_BREAK_EN
   logic              break_req;
`endif

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_frame_engine #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
      .clk1        (clk1),
      .rst         (rst),
      .clk_div     (clk_div),
      .parity_mode (parity_mode),
      .stop2       (stop2),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .txd         (txd),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done)
`ifdef UART_TX_BREAK_EN
      ,
      .break_req   (break_req)
`endif
   );

   always #5 clk1 = ~clk1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Present a word, wait for acceptance, then check every clock of the frame against the model.
   task automatic send(input logic [7:0] d, input int div, input logic [1:0] pm,
                       input logic s2, input bit chain, output int done_at);
      int unsigned bits[$];
      int len;
      int w;
      bits.push_back(0);
      for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
      if (pm == 2'b01) bits.push_back(int'(^d));
      if (pm == 2'b10) bits.push_back(int'(~^d));
      bits.push_back(1);
      if (s2) bits.push_back(1);
      len     = bits.size() * (div + 1);
      done_at = -1;
      tx_data     = d;
      clk_div     = DIV_W'(div);
      parity_mode = pm;
      stop2       = s2;
      tx_valid    = 1'b1;
      w = 0;
      while (!tx_ready && w < 200) begin
         @(negedge clk1);
         w++;
      end
      if (!tx_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         tx_valid = 1'b0;
         return;
      end
      @(posedge clk1);
      #1;
      if (!chain) begin
         tx_valid = 1'b0;
         tx_data  = 8'($urandom);
      end
      clk_div     = DIV_W'($urandom_range(0, 7));
      parity_mode = 2'($urandom);
      stop2       = 1'($urandom);
      for (int k = 0; k < len; k++) begin
         @(negedge clk1);
         chk("txd",   txd,      bits[k / (div + 1)]);
         chk("done",  tx_done,  32'(k == len - 1));
         chk("ready", tx_ready, 32'(k == len - 1));
         chk("busy",  tx_busy,  32'd1);
         if (tx_done && done_at < 0) done_at = k + 1;
      end
   endtask

   initial begin
      int d;
      int div;
      logic [1:0] pm;
      logic s2;
      logic [7:0] dat;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; clk_div = '0; parity_mode = 2'b00; stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
      break_req = 1'b0;
`endif
      repeat (2) @(negedge clk1);
      chk("rst_txd",   txd,      32'd1);
      chk("rst_ready", tx_ready, 32'd1);
      chk("rst_busy",  tx_busy,  32'd0);
      chk("rst_done",  tx_done,  32'd0);
      @(posedge clk1); #1 rst = 1'b0;
      @(negedge clk1);

      send(8'hA5, 3, 2'b00, 1'b0, 1'b0, d);
      chk("t1_done_clk", d, 40);

      send(8'h07, 2, 2'b01, 1'b0, 1'b0, d);
      chk("t2_even_len", d, 33);
      send(8'h07, 2, 2'b10, 1'b0, 1'b0, d);
      chk("t2_odd_len", d, 33);
      send(8'h07, 1, 2'b11, 1'b0, 1'b0, d);
      chk("t2_mode3_len", d, 20);

      send(8'h3C, 1, 2'b00, 1'b1, 1'b1, d);
      chk("t3_w0_len", d, 22);
      send(8'hC3, 1, 2'b00, 1'b1, 1'b1, d);
      chk("t3_w1_len", d, 22);
      send(8'h81, 1, 2'b00, 1'b1, 1'b0, d);
      chk("t3_w2_len", d, 22);

      send(8'h6E, 0, 2'b00, 1'b0, 1'b0, d);
      chk("t5_div0_len", d, 10);

      // Reset in the middle of DATA, then a clean frame.
      tx_data = 8'h3C; clk_div = DIV_W'(3); parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
      for (int w = 0; w < 200 && !tx_ready; w++) @(negedge clk1);
      @(posedge clk1); #1 tx_valid = 1'b0;
      repeat (8) @(negedge clk1);
      chk("t4_mid_busy", tx_busy, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t4_rst_txd",   txd,      32'd1);
      chk("t4_rst_ready", tx_ready, 32'd1);
      chk("t4_rst_busy",  tx_busy,  32'd0);
      @(posedge clk1); #1 rst = 1'b0;
      @(negedge clk1);
      send(8'h5A, 3, 2'b01, 1'b0, 1'b0, d);
      chk("t4_clean_len", d, 44);

      for (int n = 0; n < 40; n++) begin
         dat = 8'($urandom);
         div = $urandom_range(0, 4);
         pm  = 2'($urandom_range(0, 3));
         s2  = 1'($urandom);
         send(dat, div, pm, s2, ($urandom_range(0, 3) == 0), d);
         chk("rnd_len", d, (div + 1) * (9 + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0) + (s2 ? 2 : 1)));
      end
      tx_valid = 1'b0;

`ifdef UART_TX_BREAK_EN
      begin
         int cnt;
         bit seen;
         @(negedge clk1);
         tx_data = 8'h55; clk_div = DIV_W'(2); parity_mode = 2'b00; stop2 = 1'b0; tx_valid = 1'b1;
         for (int w = 0; w < 200 && !tx_ready; w++) @(negedge clk1);
         @(posedge clk1); #1 tx_valid = 1'b0;
         repeat (5) @(negedge clk1);
         break_req = 1'b1;
         seen = 1'b0;
         for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge clk1);
            seen = tx_done;
         end
         chk("brk_frame_done", 32'(seen), 32'd1);
         repeat (4) @(negedge clk1);
         chk("brk_txd_low", txd,      32'd0);
         chk("brk_not_ready", tx_ready, 32'd0);
         @(posedge clk1); #1 break_req = 1'b0;
         cnt = 0;
         for (int w = 0; w < 200 && !tx_ready; w++) begin
            @(negedge clk1);
            if (!tx_ready && txd) cnt++;
         end
         chk("brk_release_gap", 32'(cnt >= 3), 32'd1);
      end
`endif

      repeat (3) @(negedge clk1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
